// File: rtl/bp_c_output_collect.sv
// bp_c_output_collect: masked Boyar-Peralta bottom linear layer; packs shared S-box bytes into 32-bit shared columns.
// Define BP_OUT_INREG_EN to register z in an input stage before the linear layer (adds one cycle of latency).
module bp_c_output_collect #(
    parameter int d = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [18*d-1:0] z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*d-1:0] col,
    output logic [8*d-1:0]  byte_out
);
    // XNOR inverts share 0 only, so the masked value is complemented exactly once
    localparam logic [d-1:0] C_NOT0 = d'(1);
    logic [18*d-1:0] w_zsrc;
    logic            w_acc;
    logic [d-1:0]    w_z [18];
    logic [d-1:0]    w_t46, w_t47, w_t48, w_t49, w_t50, w_t51, w_t52, w_t53, w_t54, w_t55, w_t56;
    logic [d-1:0]    w_t57, w_t58, w_t59, w_t60, w_t61, w_t62, w_t63, w_t64, w_t65, w_t66, w_t67;
    logic [d-1:0]    w_s0, w_s1, w_s2, w_s3, w_s4, w_s5, w_s6, w_s7;
    logic [8*d-1:0]  w_byte;
    logic [32*d-1:0] r_col;
    logic [8*d-1:0]  r_byte;
    logic [1:0]      r_lane;
    logic            r_out_valid;

`ifdef BP_OUT_INREG_EN
    logic [18*d-1:0] r_z;
    logic            r_zv;
    assign in_ready = !(r_zv && r_out_valid && !out_ready);
    assign w_acc    = r_zv && (!r_out_valid || out_ready);
    assign w_zsrc   = r_z;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z  <= '0;
            r_zv <= 1'b0;
        end else if (in_ready) begin
            r_z  <= z;
            r_zv <= in_valid;
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;
    assign w_acc    = in_valid && in_ready;
    assign w_zsrc   = z;
`endif

    for (genvar k = 0; k < 18; k++) begin : g_z
        assign w_z[k] = w_zsrc[k*d +: d];
    end

    assign w_t46 = w_z[15] ^ w_z[16];
    assign w_t47 = w_z[10] ^ w_z[11];
    assign w_t48 = w_z[5] ^ w_z[13];
    assign w_t49 = w_z[9] ^ w_z[10];
    assign w_t50 = w_z[2] ^ w_z[12];
    assign w_t51 = w_z[2] ^ w_z[5];
    assign w_t52 = w_z[7] ^ w_z[8];
    assign w_t53 = w_z[0] ^ w_z[3];
    assign w_t54 = w_z[6] ^ w_z[7];
    assign w_t55 = w_z[16] ^ w_z[17];
    assign w_t56 = w_z[12] ^ w_t48;
    assign w_t57 = w_t50 ^ w_t53;
    assign w_t58 = w_z[4] ^ w_t46;
    assign w_t59 = w_z[3] ^ w_t54;
    assign w_t60 = w_t46 ^ w_t57;
    assign w_t61 = w_z[14] ^ w_t57;
    assign w_t62 = w_t52 ^ w_t58;
    assign w_t63 = w_t49 ^ w_t58;
    assign w_t64 = w_z[4] ^ w_t59;
    assign w_t65 = w_t61 ^ w_t62;
    assign w_t66 = w_z[1] ^ w_t63;
    assign w_t67 = w_t64 ^ w_t65;

    assign w_s0 = w_t59 ^ w_t63;
    assign w_s3 = w_t53 ^ w_t66;
    assign w_s1 = w_t64 ^ w_s3 ^ C_NOT0;
    assign w_s2 = w_t55 ^ w_t67 ^ C_NOT0;
    assign w_s4 = w_t51 ^ w_t66;
    assign w_s5 = w_t47 ^ w_t65;
    assign w_s6 = w_t56 ^ w_t62 ^ C_NOT0;
    assign w_s7 = w_t48 ^ w_t60 ^ C_NOT0;

    // s0 is the S-box MSB
    assign w_byte = {w_s0, w_s1, w_s2, w_s3, w_s4, w_s5, w_s6, w_s7};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_byte      <= '0;
            r_lane      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_acc) begin
                r_col[32'(r_lane)*8*d +: 8*d] <= w_byte;
                r_byte                        <= w_byte;
                r_lane                        <= r_lane + 2'd1;
            end
            r_out_valid <= (w_acc && r_lane == 2'd3) || (r_out_valid && !out_ready);
        end
    end

    assign out_valid = r_out_valid;
    assign col       = r_col;
    assign byte_out  = r_byte;
endmodule

// File: tb/tb_bp_c_output_collect.sv
// tb_bp_c_output_collect: scoreboard bench; z sets come from a bench-side Boyar-Peralta top/middle model,
// expected bytes from a GF(2^8) inverse plus affine S-box model.
module tb_bp_c_output_collect;
    localparam int D = 2;
`ifdef BP_OUT_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid;
    logic [18*D-1:0] z = '0;
    logic [32*D-1:0] col;
    logic [8*D-1:0] byte_out;
    int passed = 0, total = 0, pulses = 0, nacc = 0;
    logic [7:0] byte_q[$];
    logic [31:0] col_q[$];
    logic [31:0] acc_col = '0;
    logic [1:0] pend = '0;

    bp_c_output_collect #(.d(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .z(z),
        .out_valid(out_valid), .out_ready(out_ready), .col(col), .byte_out(byte_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] v, s;
        v = '0;
        for (int i = 1; i < 256; i++) if (gmul(a, 8'(i)) == 8'h01) v = 8'(i);
        s = 8'h63;
        for (int r = 0; r < 5; r++) s ^= (v << r) | (v >> (8 - r));
        return s;
    endfunction

    function automatic logic [17:0] zmodel(input logic [7:0] x);
        logic u0, u1, u2, u3, u4, u5, u6, u7;
        logic y1, y2, y3, y4, y5, y6, y7, y8, y9, y10, y11, y12, y13, y14, y15, y16, y17, y18, y19, y20, y21;
        logic t0, t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, t11, t12, t13, t14, t15, t16, t17, t18, t19, t20;
        logic t21, t22, t23, t24, t25, t26, t27, t28, t29, t30, t31, t32, t33, t34, t35, t36, t37, t38, t39;
        logic t40, t41, t42, t43, t44, t45;
        {u0, u1, u2, u3, u4, u5, u6, u7} = x;
        y14 = u3 ^ u5; y13 = u0 ^ u6; y9 = u0 ^ u3; y8 = u0 ^ u5; t0 = u1 ^ u2;
        y1 = t0 ^ u7; y4 = y1 ^ u3; y12 = y13 ^ y14; y2 = y1 ^ u0; y5 = y1 ^ u6;
        y3 = y5 ^ y8; t1 = u4 ^ y12; y15 = t1 ^ u5; y20 = t1 ^ u1; y6 = y15 ^ u7;
        y10 = y15 ^ t0; y11 = y20 ^ y9; y7 = u7 ^ y11; y17 = y10 ^ y11; y19 = y10 ^ y8;
        y16 = t0 ^ y11; y21 = y13 ^ y16; y18 = u0 ^ y16;
        t2 = y12 & y15; t3 = y3 & y6; t4 = t3 ^ t2; t5 = y4 & u7; t6 = t5 ^ t2;
        t7 = y13 & y16; t8 = y5 & y1; t9 = t8 ^ t7; t10 = y2 & y7; t11 = t10 ^ t7;
        t12 = y9 & y11; t13 = y14 & y17; t14 = t13 ^ t12; t15 = y8 & y10; t16 = t15 ^ t12;
        t17 = t4 ^ t14; t18 = t6 ^ t16; t19 = t9 ^ t14; t20 = t11 ^ t16;
        t21 = t17 ^ y20; t22 = t18 ^ y19; t23 = t19 ^ y21; t24 = t20 ^ y18;
        t25 = t21 ^ t22; t26 = t21 & t23; t27 = t24 ^ t26; t28 = t25 & t27; t29 = t28 ^ t22;
        t30 = t23 ^ t24; t31 = t22 ^ t26; t32 = t31 & t30; t33 = t32 ^ t24; t34 = t23 ^ t33;
        t35 = t27 ^ t33; t36 = t24 & t35; t37 = t36 ^ t34; t38 = t27 ^ t36; t39 = t29 & t38;
        t40 = t25 ^ t39; t41 = t40 ^ t37; t42 = t29 ^ t33; t43 = t29 ^ t40; t44 = t33 ^ t37;
        t45 = t42 ^ t41;
        return {t41 & y8, t45 & y14, t42 & y9, t29 & y2, t40 & y5, t43 & y13, t33 & y4, t37 & y3, t44 & y12,
                t41 & y10, t45 & y17, t42 & y11, t29 & y7, t40 & y1, t43 & y16, t33 & u7, t37 & y6, t44 & y15};
    endfunction

    function automatic logic [18*D-1:0] mask_z(input logic [7:0] x);
        logic [17:0] zu;
        logic [18*D-1:0] m;
        logic [D-1:0] sh;
        zu = zmodel(x);
        for (int k = 0; k < 18; k++) begin
            sh = D'($urandom);
            sh[0] = zu[k] ^ (^sh[D-1:1]);
            m[k*D +: D] = sh;
        end
        return m;
    endfunction

    function automatic logic [7:0] rec8(input logic [8*D-1:0] v);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = ^v[b*D +: D];
        return r;
    endfunction

    function automatic logic [31:0] rec32(input logic [32*D-1:0] v);
        logic [31:0] r;
        for (int b = 0; b < 32; b++) r[b] = ^v[b*D +: D];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic note_accept(input logic [7:0] x);
        byte_q.push_back(sbox_ref(x));
        acc_col[8*nacc +: 8] = sbox_ref(x);
        nacc++;
        if (nacc == 4) begin
            col_q.push_back(acc_col);
            nacc = 0;
        end
    endtask

    task automatic send(input logic [7:0] x);
        logic ok;
        ok = 1'b0;
        z = mask_z(x);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accept", 64'(ok), 64'd1);
        if (ok) note_accept(x);
    endtask

    // byte_out follows each accept by LAT edges; columns are checked at the handshake
    always @(negedge clk) begin
        if (!rst_n) pend = '0;
        else begin
            if (pend[LAT-1]) begin
                chk("byte_q_nonempty", 64'(byte_q.size() > 0), 64'd1);
                if (byte_q.size() > 0) chk("byte_out", 64'(rec8(byte_out)), 64'(byte_q.pop_front()));
            end
            pend = {pend[0], in_valid && in_ready};
            if (out_valid && out_ready) begin
                pulses++;
                chk("col_q_nonempty", 64'(col_q.size() > 0), 64'd1);
                if (col_q.size() > 0) chk("col", 64'(rec32(col)), 64'(col_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    initial begin
        int lat, p0;
        time t0;
        logic [32*D-1:0] held;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_col", 64'(col), 64'd0);
        chk("rst_byte_out", 64'(byte_out), 64'd0);

        // reference bytes, back to back
        p0 = pulses;
        t0 = $time;
        send(8'h00); send(8'h01); send(8'h53); send(8'hFF);
        in_valid = 1'b0;
        chk("s1_throughput", 64'($time - t0), 64'd40);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("s1_latency", 64'(lat), 64'(LAT));
        chk("s1_col", 64'(rec32(col)), 64'h16ED7C63);
        @(posedge clk);
        #1;
        chk("s1_pulse_low", 64'(out_valid), 64'd0);
        chk("s1_pulses", 64'(pulses - p0), 64'd1);

        // all 256 inputs
        p0 = pulses;
        for (int i = 0; i < 256; i++) send(8'(i));
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("all_pulses", 64'(pulses - p0), 64'd64);

        // backpressure with in_valid held
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i));
        z = mask_z(8'hA5);
        in_valid = 1'b1;
        held = col;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_col_frozen", 64'(col), 64'(held));
        chk("bp_lane", 64'(dut.r_lane), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        note_accept(8'hA5);
        chk("bp_out_valid_clr", 64'(out_valid), 64'd0);
        chk("bp_lane_after", 64'(dut.r_lane), 64'd1);
        out_ready = 1'b1;
        send(8'hB6); send(8'hC7); send(8'hD8);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // in_valid gap mid-column
        p0 = pulses;
        send(8'h21); send(8'h32);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("gap_lane", 64'(dut.r_lane), 64'd2);
        chk("gap_out_valid", 64'(out_valid), 64'd0);
        send(8'h43); send(8'h54);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("gap_pulses", 64'(pulses - p0), 64'd1);

        // asynchronous reset after three accepts
        send(8'h60); send(8'h61); send(8'h62);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_col", 64'(col), 64'd0);
        chk("arst_byte_out", 64'(byte_out), 64'd0);
        chk("arst_lane", 64'(dut.r_lane), 64'd0);
        byte_q.delete();
        nacc = 0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 4; i++) send(8'(8'h70 + i));
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("arst_fresh_pulses", 64'(pulses - p0), 64'd1);
        chk("col_q_drained", 64'(col_q.size()), 64'd0);
        chk("byte_q_drained", 64'(byte_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
